// File: rtl/relation_pkg.sv
// Shared definitions for the relation_tracker frame analyser: default sample
// width and the registered FSM state encoding.
package relation_pkg;

  localparam int W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/rel_cmp.sv
// Unsigned magnitude comparator; exactly one of lt/eq/gt is high.
module rel_cmp #(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/relation_tracker.sv
// Per-frame min/max and rising/falling/equal step counts over a valid/ready
// sample stream, reported through a second valid/ready handshake.
module relation_tracker
  import relation_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     min_val,
  output logic [W-1:0]     max_val,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] smp_cnt;
  logic [W-1:0]     prev_val;
  logic             accept, first_smp, last_smp;

  // Relation vectors ordered {gt, eq, lt}; each is one-hot.
  logic [2:0] step_rel, min_rel, max_rel;

  logic [W-1:0]     min_nxt, max_nxt;
  logic [CNT_W-1:0] rise_nxt, fall_nxt, eq_nxt;

  rel_cmp #(.W(W)) u_cmp_step (
    .a(in_data), .b(prev_val), .lt(step_rel[0]), .eq(step_rel[1]), .gt(step_rel[2])
  );
  rel_cmp #(.W(W)) u_cmp_min (
    .a(in_data), .b(min_val), .lt(min_rel[0]), .eq(min_rel[1]), .gt(min_rel[2])
  );
  rel_cmp #(.W(W)) u_cmp_max (
    .a(in_data), .b(max_val), .lt(max_rel[0]), .eq(max_rel[1]), .gt(max_rel[2])
  );

  // Handshake outputs decode the registered state only.
  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_REPORT);
  assign busy      = (state != ST_IDLE);

  assign accept    = in_ready && in_valid;
  assign first_smp = (smp_cnt == '0);
  assign last_smp  = (smp_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start)              state_nxt = ST_ACCUM;
      ST_ACCUM:  if (accept && last_smp) state_nxt = ST_REPORT;
      ST_REPORT: if (out_ready)          state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rise_nxt = rise_cnt;
    fall_nxt = fall_cnt;
    eq_nxt   = eq_cnt;
    min_nxt  = min_val;
    max_nxt  = max_val;
    case (step_rel)
      3'b100:  rise_nxt = rise_cnt + 1'b1;
      3'b010:  eq_nxt   = eq_cnt + 1'b1;
      3'b001:  fall_nxt = fall_cnt + 1'b1;
      default: ;
    endcase
    case (min_rel)
      3'b001:  min_nxt = in_data;
      default: ;
    endcase
    case (max_rel)
      3'b100:  max_nxt = in_data;
      default: ;
    endcase
  end

  // Report registers: cleared on start, updated per accepted sample, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt  <= '0;
      min_val  <= '0;
      max_val  <= '0;
      rise_cnt <= '0;
      fall_cnt <= '0;
      eq_cnt   <= '0;
    end else if (state == ST_IDLE && start) begin
      smp_cnt  <= '0;
      rise_cnt <= '0;
      fall_cnt <= '0;
      eq_cnt   <= '0;
    end else if (accept) begin
      smp_cnt <= smp_cnt + 1'b1;
      if (first_smp) begin
        min_val <= in_data;
        max_val <= in_data;
      end else begin
        min_val  <= min_nxt;
        max_val  <= max_nxt;
        rise_cnt <= rise_nxt;
        fall_cnt <= fall_nxt;
        eq_cnt   <= eq_nxt;
      end
    end
  end

  // prev is only ever read after the first sample of a frame has loaded it.
  always_ff @(posedge clk) begin
    if (accept) prev_val <= in_data;
  end

endmodule

// File: tb/tb_relation_tracker.sv
// Self-checking bench for relation_tracker: directed vector table, random
// frames against a behavioural model, and multi-cycle corner sequences.
module tb_relation_tracker;

  localparam int W         = 3;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     min_val;
  logic [W-1:0]     max_val;
  logic [CNT_W-1:0] rise_cnt;
  logic [CNT_W-1:0] fall_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic             busy;

  relation_tracker #(.W(W), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .min_val(min_val), .max_val(max_val), .rise_cnt(rise_cnt), .fall_cnt(fall_cnt),
    .eq_cnt(eq_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef logic [FRAME_LEN-1:0][W-1:0] frame_t;

  typedef struct {
    frame_t s;
    bit     gaps;
    int     emin, emax, er, ef, ee;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  logic [W-1:0] cur [FRAME_LEN];
  vec_t       tbl [4];

  function automatic frame_t pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {W'(a7), W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_report(input string tag, input int emin, emax, er, ef, ee);
    chk({tag, " min"},  int'(min_val),  emin);
    chk({tag, " max"},  int'(max_val),  emax);
    chk({tag, " rise"}, int'(rise_cnt), er);
    chk({tag, " fall"}, int'(fall_cnt), ef);
    chk({tag, " eq"},   int'(eq_cnt),   ee);
  endtask

  // Reference: plain arithmetic over the sample list.
  task automatic model(output int mn, mx, r, f, e);
    mn = cur[0]; mx = cur[0]; r = 0; f = 0; e = 0;
    for (int k = 1; k < FRAME_LEN; k++) begin
      if (cur[k] < mn) mn = cur[k];
      if (cur[k] > mx) mx = cur[k];
      if (cur[k] > cur[k-1])      r++;
      else if (cur[k] < cur[k-1]) f++;
      else                        e++;
    end
  endtask

  // Starts a frame, feeds cur[] and leaves the bench one #1 after the last accept.
  task automatic run_frame(input string tag, input bit gaps, input bit start_in_accum);
    int   idx;
    int   cyc;
    logic rdy;
    start = 1'b1;
    @(posedge clk); #1;
    start = start_in_accum;
    chk({tag, " in_ready after start"}, int'(in_ready), 1);
    chk({tag, " busy in accum"},        int'(busy),     1);
    idx = 0;
    cyc = 0;
    while (idx < FRAME_LEN && cyc < 400) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? cur[idx] : W'($urandom);
      rdy      = in_ready;
      @(posedge clk); #1;
      if (in_valid && rdy) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk({tag, " samples accepted"},   idx,              FRAME_LEN);
    chk({tag, " out_valid at report"}, int'(out_valid), 1);
    chk({tag, " in_ready at report"},  int'(in_ready),  0);
  endtask

  initial begin
    int mn, mx, r, f, e;
    int hold_min, hold_max;

    tbl[0] = '{pack8(3, 5, 5, 2, 7, 7, 1, 4), 1'b0, 1, 7, 3, 2, 2};
    tbl[1] = '{pack8(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0, 0, 0, 0, 7};
    tbl[2] = '{pack8(0, 1, 2, 3, 4, 5, 6, 7), 1'b1, 0, 7, 7, 0, 0};
    tbl[3] = '{pack8(6, 2, 6, 2, 6, 2, 6, 2), 1'b1, 2, 6, 3, 4, 0};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready",  int'(in_ready),  0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset busy",      int'(busy),      0);
    check_report("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle without start", int'(busy), 0);

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < FRAME_LEN; k++) cur[k] = tbl[i].s[k];
      run_frame($sformatf("vec%0d", i), tbl[i].gaps, 1'b0);
      check_report($sformatf("vec%0d", i), tbl[i].emin, tbl[i].emax, tbl[i].er, tbl[i].ef, tbl[i].ee);
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid one cycle", i), int'(out_valid), 0);
      chk($sformatf("vec%0d idle after report", i),   int'(busy),      0);
      chk($sformatf("vec%0d min held in idle", i),    int'(min_val),   tbl[i].emin);
    end

    // Random frames against the model.
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < FRAME_LEN; k++) cur[k] = W'($urandom);
      model(mn, mx, r, f, e);
      run_frame($sformatf("rnd%0d", i), bit'($urandom_range(0, 1)), 1'b0);
      check_report($sformatf("rnd%0d", i), mn, mx, r, f, e);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d out_valid one cycle", i), int'(out_valid), 0);
    end

    // Backpressure in REPORT with start and in_valid noise.
    out_ready = 1'b0;
    for (int k = 0; k < FRAME_LEN; k++) cur[k] = W'($urandom);
    model(mn, mx, r, f, e);
    run_frame("bp", 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; in_valid = 1'b1; in_data = W'($urandom);
      @(posedge clk); #1;
      chk($sformatf("bp out_valid c%0d", c), int'(out_valid), 1);
      chk($sformatf("bp in_ready c%0d", c),  int'(in_ready),  0);
      check_report($sformatf("bp c%0d", c), mn, mx, r, f, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    chk("bp idle after handshake", int'(busy),      0);
    chk("bp out_valid dropped",    int'(out_valid), 0);
    check_report("bp held in idle", mn, mx, r, f, e);
    @(posedge clk); #1;
    chk("bp start at handshake ignored", int'(busy),     0);
    chk("bp in_ready stays low",         int'(in_ready), 0);

    // Asynchronous reset mid-frame.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = W'(k + 3);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid busy before reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid reset in_ready",  int'(in_ready),  0);
    chk("mid reset out_valid", int'(out_valid), 0);
    chk("mid reset busy",      int'(busy),      0);
    check_report("mid reset", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < FRAME_LEN; k++) cur[k] = W'(7 - k);
    run_frame("after reset", 1'b0, 1'b0);
    check_report("after reset", 0, 7, 0, 7, 0);
    @(posedge clk); #1;

    // start held through ACCUM must not restart the frame.
    for (int k = 0; k < FRAME_LEN; k++) cur[k] = W'($urandom);
    model(mn, mx, r, f, e);
    run_frame("restart", 1'b1, 1'b1);
    check_report("restart", mn, mx, r, f, e);
    @(posedge clk); #1;
    chk("restart idle after report", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/relation_tracker.md
# relation_tracker

Streaming frame analyser built around an unsigned magnitude compare. It accepts a frame of FRAME_LEN W-bit samples over a valid/ready handshake and compares each sample against its predecessor and against the running extremes. It reports the frame minimum, the frame maximum and counts of rising, falling and equal steps. It sits downstream of the sample source and feeds the status/report logic through a second valid/ready handshake.

## Interface
- W, 3, sample width in bits; samples are unsigned
- FRAME_LEN, 8, samples per frame; must be ≥ 2
- CNT_W, 4, counter width; must satisfy 2^CNT_W > FRAME_LEN
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- in_valid  in  1  in_data is valid
- in_data  in  W  sample
- in_ready  out  1  block accepts a sample this cycle
- out_valid  out  1  report is valid
- out_ready  in  1  consumer takes the report
- min_val  out  W  smallest sample in the frame
- max_val  out  W  largest sample in the frame
- rise_cnt  out  CNT_W  number of steps where sample > previous
- fall_cnt  out  CNT_W  number of steps where sample < previous
- eq_cnt  out  CNT_W  number of steps where sample == previous
- busy  out  1  high in ACCUM and REPORT

## Operation
- States: IDLE, ACCUM, REPORT; encoded as 2-bit registered state.
- IDLE: in_ready=0, out_valid=0. If start=1, go to ACCUM and clear the sample counter, rise_cnt, fall_cnt and eq_cnt.
- ACCUM: in_ready=1. A sample is accepted when in_valid && in_ready.
  - First accepted sample: min=max=prev=sample. No step counter changes.
  - Each later sample: compare the sample with prev.
    - Exactly one of rise_cnt, fall_cnt or eq_cnt increments, for gt, lt or eq respectively.
    - If sample < min, min takes the sample value. If sample > max, max takes the sample value.
    - prev takes the sample value.
  - When the FRAME_LEN-th sample is accepted, go to REPORT.
- REPORT: in_ready=0, out_valid=1. All report outputs hold stable. When out_ready=1, go to IDLE.
- Invariant at REPORT: rise_cnt + fall_cnt + eq_cnt = FRAME_LEN−1.
- Report outputs keep their last values in IDLE. They change only during ACCUM of the next frame.
- start is ignored in ACCUM and REPORT. A start in the same cycle as the REPORT handshake is ignored; the consumer must reassert it in IDLE.
- in_valid is ignored outside ACCUM. No sample is dropped or double-counted.
- All compares are unsigned W-bit. Counters never wrap because of the CNT_W constraint.

## Timing
- Reset (rst_n=0, any state, including mid-frame):
  - state=IDLE
  - in_ready=0, out_valid=0, busy=0
  - min_val=0, max_val=0, rise_cnt=0, fall_cnt=0, eq_cnt=0
  - the partial frame is discarded
- start sampled at edge t: in_ready=1 from cycle t+1.
- Last sample accepted at edge k: out_valid=1 from cycle k+1, with final values valid in that same cycle.
- in_ready, out_valid and busy are decoded from the registered state only. They have no combinational path from in_valid, out_ready or start.
- Minimum frame time: 1 + FRAME_LEN + 1 cycles (start, samples, report handshake), with no input gaps and out_ready held high.
- Gaps in in_valid stall accumulation without limit. Backpressure on out_ready holds REPORT without limit.

## Structure
- Package relation_pkg holds:
  - state localparams ST_IDLE, ST_ACCUM, ST_REPORT
  - default W
- Sub-module rel_cmp: combinational, parameter W; inputs a, b; outputs lt, eq, gt, exactly one of which is high.
- relation_tracker instantiates three rel_cmp:
  - sample vs prev, for the step counters
  - sample vs min
  - sample vs max
- Top level holds the FSM, sample counter, registers and handshake.

## Test plan
- Frame 3,5,5,2,7,7,1,4, no gaps, out_ready=1 → min=1, max=7, rise=3, fall=2, eq=2; out_valid exactly one cycle.
- Frame of eight 0s → min=0, max=0, rise=0, fall=0, eq=7.
- Frame 0..7 ascending with random in_valid gaps → min=0, max=7, rise=7, fall=0, eq=0; no extra samples consumed.
- Hold out_ready=0 for 5 cycles in REPORT, pulse start and drive in_valid meanwhile → outputs stable, in_ready=0, start ignored, state stays REPORT until out_ready.
- Assert rst_n=0 after 4 samples of a frame → all outputs 0, IDLE. Next frame 7,6,5,4,3,2,1,0 → min=0, max=7, fall=7.
- Pulse start during ACCUM → frame is not restarted; counts match an uninterrupted frame.
